load_use_scoreboard: RTL and testbench
======================================

# load_use_scoreboard

Parametrised load-use hazard unit for the five-stage pipeline, sitting between the D/X/M pipeline registers and the stall/bubble logic. It tracks load destinations from X through a configurable number of extra memory-latency stages and stalls D while any source register is still pending. It also honours a global pipeline freeze and keeps a saturating count of stall cycles. With LOAD_LATENCY = 0 it reproduces the single-cycle X-stage load-use stall.

## Interface
- REG_BITS, 5: register-index width; register 0 is hard-wired zero.
- LOAD_LATENCY, 0: extra cycles after X before load data can be forwarded; range 0..7.
- STORE_DATA_FWD, 1: 1 = a store's data register (rt) never causes a stall because it is forwarded into M; 0 = it stalls like any source.
- CNT_BITS, 32: width of the stall counter.
- clock  in  1: sole clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- hold  in  1: global freeze (multdiv busy, memory wait); the pipeline does not advance this cycle.
- d_valid  in  1: D holds a real (non-flushed, non-bubble) instruction.
- d_rs  in  REG_BITS: D source register 1.
- d_rs_used  in  1: D reads rs.
- d_rt  in  REG_BITS: D source register 2.
- d_rt_used  in  1: D reads rt.
- d_is_store  in  1: D is sw.
- x_valid  in  1: X holds a real instruction.
- x_is_load  in  1: X is lw.
- x_rd  in  REG_BITS: X load destination.
- stall  out  1: hold F/D this cycle and insert a bubble into X.
- pending_mask  out  LOAD_LATENCY+1: bit 0 is the live X load; bit k is occupied pend[k-1].
- stall_count  out  CNT_BITS: saturating count of stall cycles.

## Operation
- The X entry is combinational: valid = x_valid & x_is_load & (x_rd != 0); tag = x_rd.
- pend[0..LOAD_LATENCY-1] form a registered shift chain of {valid, tag}. When LOAD_LATENCY = 0 there are no registers; use a generate guard.
- Shift rule, when hold = 0: pend[0] <= X entry; pend[k] <= pend[k-1]. When hold = 1, every pend entry keeps its value.
- rs_hit = d_rs_used & (d_rs != 0) & any valid entry (X or pend) with tag == d_rs.
- rt_hit = d_rt_used & (d_rt != 0) & any valid entry with tag == d_rt & ~(STORE_DATA_FWD & d_is_store).
- stall = d_valid & (rs_hit | rt_hit) & ~reset.
- stall is asserted regardless of hold. External logic ORs them; this block does not gate stall with hold.
- Because the bubble enters X on a stall, the X entry is invalid next cycle. The chain drains naturally and stall drops as soon as no matching entry remains.
- Worst-case stall for an immediately dependent instruction is LOAD_LATENCY + 1 cycles.
- Duplicate tags across entries are legal; a match on any of them stalls.
- stall_count increments when stall & ~hold, and saturates at 2^CNT_BITS - 1 with no wrap.
- Reset, including mid-stall: pend valid bits = 0, stall_count = 0, stall = 0 immediately. After deassertion, the X entry alone can raise stall combinationally in the same cycle.

## Timing
- stall and pending_mask[0] are combinational from the current inputs, with zero latency.
- pending_mask[LOAD_LATENCY:1] and stall_count are registered.
- A load in X at edge n occupies pend[k] during cycle n+k+1.
- Reset values: pend all invalid, pending_mask = 0 (bit 0 follows the inputs once reset is released), stall_count = 0, stall = 0.
- Simultaneous stall and hold: the chain holds, stall stays 1, and the counter does not increment.

## Test plan
- LOAD_LATENCY = 0, X = lw $5, D = add rs = 5 -> stall = 1 for one cycle. Next cycle, with X a bubble, stall = 0 and stall_count = 1.
- LOAD_LATENCY = 2, X = lw $7, D = sub rt = 7, no hold -> stall = 1 for exactly 3 cycles; pending_mask = 001, 010, 100, then 000; stall_count = 3.
- STORE_DATA_FWD = 1, X = lw $9, D = sw with rt = 9, rs = 3 -> stall = 0. Repeat with STORE_DATA_FWD = 0 -> stall = 1.
- x_rd = 0 lw, then d_rs = 0 -> stall = 0, pending_mask = 0.
- LOAD_LATENCY = 1, lw $4 in pend[0], hold = 1 for 3 cycles -> pend[0] is retained, stall stays 1, stall_count unchanged. When hold drops, one more stall cycle is counted, then stall = 0.
- Mid-stall async reset (LOAD_LATENCY = 3, entry in pend[1]) -> stall = 0 and pending_mask = 0 without a clock edge; stall_count = 0. Separately, with CNT_BITS = 4, force 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight load destinations from X through
// LOAD_LATENCY extra stages and stalls D while any used source is still pending.
module lus_entry_match #(
  parameter int REG_BITS = 5
) (
  input  logic                vld,
  input  logic [REG_BITS-1:0] tag,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  output logic                rs_match,
  output logic                rt_match
);
  assign rs_match = vld & (tag == rs);
  assign rt_match = vld & (tag == rt);
endmodule

module load_use_scoreboard #(
  parameter int REG_BITS       = 5,
  parameter int LOAD_LATENCY   = 0,
  parameter int STORE_DATA_FWD = 1,
  parameter int CNT_BITS       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  d_valid,
  input  logic [REG_BITS-1:0]   d_rs,
  input  logic                  d_rs_used,
  input  logic [REG_BITS-1:0]   d_rt,
  input  logic                  d_rt_used,
  input  logic                  d_is_store,
  input  logic                  x_valid,
  input  logic                  x_is_load,
  input  logic [REG_BITS-1:0]   x_rd,
  output logic                  stall,
  output logic [LOAD_LATENCY:0] pending_mask,
  output logic [CNT_BITS-1:0]   stall_count
);
  localparam int   ENTRIES = LOAD_LATENCY + 1;
  localparam logic FWD_EN  = (STORE_DATA_FWD != 0);

  logic                               x_ent_vld;
  logic [ENTRIES-1:0]                 ent_vld;
  logic [ENTRIES-1:0][REG_BITS-1:0]   ent_tag;
  logic [ENTRIES-1:0]                 rs_match;
  logic [ENTRIES-1:0]                 rt_match;
  logic [ENTRIES-1:0]                 rst_gate;
  logic                               rs_hit;
  logic                               rt_hit;

  // Writes to $0 never create a hazard, so they never occupy an entry.
  assign x_ent_vld  = x_valid & x_is_load & (x_rd != '0);
  assign ent_vld[0] = x_ent_vld;
  assign ent_tag[0] = x_rd;

  generate
    if (LOAD_LATENCY > 0) begin : g_pend
      logic [LOAD_LATENCY-1:0]               pend_vld;
      logic [LOAD_LATENCY-1:0][REG_BITS-1:0] pend_tag;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pend_vld <= '0;
          pend_tag <= '0;
        end else if (!hold) begin
          pend_vld[0] <= x_ent_vld;
          pend_tag[0] <= x_rd;
          for (int k = 1; k < LOAD_LATENCY; k++) begin
            pend_vld[k] <= pend_vld[k-1];
            pend_tag[k] <= pend_tag[k-1];
          end
        end
      end

      assign ent_vld[ENTRIES-1:1] = pend_vld;
      assign ent_tag[ENTRIES-1:1] = pend_tag;
    end
  endgenerate

  generate
    for (genvar e = 0; e < ENTRIES; e++) begin : g_match
      lus_entry_match #(.REG_BITS(REG_BITS)) u_match (
        .vld      (ent_vld[e]),
        .tag      (ent_tag[e]),
        .rs       (d_rs),
        .rt       (d_rt),
        .rs_match (rs_match[e]),
        .rt_match (rt_match[e])
      );
    end
  endgenerate

  assign rs_hit = d_rs_used & (d_rs != '0) & (|rs_match);
  // Store data is forwarded into M, so it can wait on the load without stalling D.
  assign rt_hit = d_rt_used & (d_rt != '0) & (|rt_match) & ~(FWD_EN & d_is_store);
  assign stall  = d_valid & (rs_hit | rt_hit) & ~reset;

  // The live X entry is combinational; mask it off while reset is held.
  always_comb begin
    rst_gate    = '1;
    rst_gate[0] = ~reset;
  end
  assign pending_mask = ent_vld & rst_gate;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && !hold && (stall_count != '1))
      stall_count <= stall_count + CNT_BITS'(1);
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomized + directed bench for load_use_scoreboard across four parameter sets,
// checked every cycle against a load-history reference model.
module tb_load_use_scoreboard;
  logic       clock = 0;
  logic       reset, hold, d_valid, d_rs_used, d_rt_used, d_is_store;
  logic       x_valid, x_is_load;
  logic [4:0] d_rs, d_rt, x_rd;

  logic [3:0]  stall_v;
  logic [0:0]  m0;
  logic [1:0]  m1;
  logic [2:0]  m2;
  logic [3:0]  m3;
  logic [31:0] c0, c2;
  logic [3:0]  c1, c3;
  logic [7:0]  got_mask [4];
  logic [31:0] got_cnt  [4];

  int errs = 0;
  int checks = 0;

  localparam int LAT [4] = '{0, 1, 2, 3};
  localparam int FWD [4] = '{1, 0, 1, 0};
  localparam int CB  [4] = '{32, 4, 32, 4};

  always #5 clock = ~clock;

  load_use_scoreboard #(.REG_BITS(5), .LOAD_LATENCY(0), .STORE_DATA_FWD(1), .CNT_BITS(32)) u0 (
    .clock(clock), .reset(reset), .hold(hold), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
    .d_rt(d_rt), .d_rt_used(d_rt_used), .d_is_store(d_is_store), .x_valid(x_valid), .x_is_load(x_is_load),
    .x_rd(x_rd), .stall(stall_v[0]), .pending_mask(m0), .stall_count(c0));
  load_use_scoreboard #(.REG_BITS(5), .LOAD_LATENCY(1), .STORE_DATA_FWD(0), .CNT_BITS(4)) u1 (
    .clock(clock), .reset(reset), .hold(hold), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
    .d_rt(d_rt), .d_rt_used(d_rt_used), .d_is_store(d_is_store), .x_valid(x_valid), .x_is_load(x_is_load),
    .x_rd(x_rd), .stall(stall_v[1]), .pending_mask(m1), .stall_count(c1));
  load_use_scoreboard #(.REG_BITS(5), .LOAD_LATENCY(2), .STORE_DATA_FWD(1), .CNT_BITS(32)) u2 (
    .clock(clock), .reset(reset), .hold(hold), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
    .d_rt(d_rt), .d_rt_used(d_rt_used), .d_is_store(d_is_store), .x_valid(x_valid), .x_is_load(x_is_load),
    .x_rd(x_rd), .stall(stall_v[2]), .pending_mask(m2), .stall_count(c2));
  load_use_scoreboard #(.REG_BITS(5), .LOAD_LATENCY(3), .STORE_DATA_FWD(0), .CNT_BITS(4)) u3 (
    .clock(clock), .reset(reset), .hold(hold), .d_valid(d_valid), .d_rs(d_rs), .d_rs_used(d_rs_used),
    .d_rt(d_rt), .d_rt_used(d_rt_used), .d_is_store(d_is_store), .x_valid(x_valid), .x_is_load(x_is_load),
    .x_rd(x_rd), .stall(stall_v[3]), .pending_mask(m3), .stall_count(c3));

  assign got_mask[0] = {7'b0, m0};
  assign got_mask[1] = {6'b0, m1};
  assign got_mask[2] = {5'b0, m2};
  assign got_mask[3] = {4'b0, m3};
  assign got_cnt[0]  = c0;
  assign got_cnt[1]  = {28'b0, c1};
  assign got_cnt[2]  = c2;
  assign got_cnt[3]  = {28'b0, c3};

  // Model: hv/ht[i][k] = X-stage load seen k+1 advancing edges ago.
  logic        hv [4][8];
  logic [4:0]  ht [4][8];
  logic [31:0] mcnt [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic loaded(int i, logic [4:0] r);
    logic h;
    h = x_valid && x_is_load && x_rd != 0 && x_rd == r;
    for (int k = 0; k < LAT[i]; k++)
      if (hv[i][k] && ht[i][k] == r) h = 1'b1;
    return h;
  endfunction

  function automatic logic exp_stall(int i);
    logic a, b;
    a = d_rs_used && d_rs != 0 && loaded(i, d_rs);
    b = d_rt_used && d_rt != 0 && loaded(i, d_rt) && !(FWD[i] == 1 && d_is_store);
    return !reset && d_valid && (a || b);
  endfunction

  function automatic logic [31:0] cmax(int i);
    return (CB[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CB[i]) - 32'd1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      for (int k = 0; k < 8; k++) begin hv[i][k] = 0; ht[i][k] = 0; end
    end
  endtask

  task automatic model_check();
    logic [7:0] em;
    if (reset) model_clear();
    for (int i = 0; i < 4; i++) begin
      em = 0;
      em[0] = !reset && x_valid && x_is_load && x_rd != 0;
      for (int k = 0; k < LAT[i]; k++) em[k+1] = hv[i][k];
      chk($sformatf("stall%0d", i), {31'b0, stall_v[i]}, {31'b0, exp_stall(i)});
      chk($sformatf("mask%0d", i), {24'b0, got_mask[i]}, {24'b0, em});
      chk($sformatf("count%0d", i), got_cnt[i], mcnt[i]);
    end
  endtask

  task automatic model_update();
    logic s;
    if (reset) begin model_clear(); return; end
    for (int i = 0; i < 4; i++) begin
      s = exp_stall(i);
      if (!hold) begin
        for (int k = 7; k > 0; k--) begin hv[i][k] = hv[i][k-1]; ht[i][k] = ht[i][k-1]; end
        hv[i][0] = x_valid && x_is_load && x_rd != 0;
        ht[i][0] = x_rd;
        if (s && mcnt[i] != cmax(i)) mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  task automatic settle();  @(negedge clock); model_check(); endtask
  task automatic advance(); @(posedge clock); model_update(); #1; endtask
  task automatic tick();    settle(); advance(); endtask

  task automatic drive(input logic h, input logic dv, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic st,
                       input logic xv, input logic xl, input logic [4:0] rd);
    hold = h; d_valid = dv; d_rs = rs; d_rs_used = rsu; d_rt = rt; d_rt_used = rtu;
    d_is_store = st; x_valid = xv; x_is_load = xl; x_rd = rd;
  endtask

  task automatic do_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
  endtask

  initial begin
    logic [7:0] m2_exp [4];
    m2_exp = '{8'h1, 8'h2, 8'h4, 8'h0};
    model_clear();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_stall", {28'b0, stall_v}, 0);
    chk("rst_mask3", {24'b0, got_mask[3]}, 0);
    chk("rst_cnt0", got_cnt[0], 0);
    do_reset();

    // lw $5 in X, add rs=5 in D; bubble follows.
    drive(0, 1, 5, 1, 0, 0, 0, 1, 1, 5);
    settle(); chk("lat0_stall", {31'b0, stall_v[0]}, 1); advance();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    settle(); chk("lat0_release", {31'b0, stall_v[0]}, 0); chk("lat0_cnt", got_cnt[0], 1); advance();

    // lw $7, sub rt=7 through LOAD_LATENCY=2.
    do_reset();
    drive(0, 1, 0, 0, 7, 1, 0, 1, 1, 7);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("lat2_stall", {31'b0, stall_v[2]}, (c < 3) ? 32'd1 : 32'd0);
      chk("lat2_mask", {24'b0, got_mask[2]}, {24'b0, m2_exp[c]});
      advance();
      drive(0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    end
    chk("lat2_cnt", got_cnt[2], 3);

    // sw with rt=9 behind lw $9.
    do_reset();
    drive(0, 1, 3, 1, 9, 1, 1, 1, 1, 9);
    settle();
    chk("st_fwd", {31'b0, stall_v[0]}, 0);
    chk("st_nofwd", {31'b0, stall_v[1]}, 1);
    advance();

    // lw $0 and a read of $0 never hazard.
    do_reset();
    drive(0, 1, 0, 1, 0, 1, 0, 1, 1, 0);
    settle();
    chk("r0_stall", {28'b0, stall_v}, 0);
    chk("r0_mask", {24'b0, got_mask[3]}, 0);
    advance();

    // Hold with a pending load in pend[0] (LOAD_LATENCY=1).
    do_reset();
    drive(0, 1, 4, 1, 0, 0, 0, 1, 1, 4);
    tick();
    drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      settle(); chk("hold_stall", {31'b0, stall_v[1]}, 1); chk("hold_cnt", got_cnt[1], 1); advance();
    end
    drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    settle(); chk("hold_done", {31'b0, stall_v[1]}, 0); chk("hold_cnt2", got_cnt[1], 2); advance();

    // Async reset while a load sits in pend[1] of the LOAD_LATENCY=3 unit.
    do_reset();
    drive(0, 1, 6, 1, 0, 0, 0, 1, 1, 6);
    tick();
    drive(0, 1, 6, 1, 0, 0, 0, 0, 0, 0);
    tick();
    settle(); chk("pre_rst_stall", {31'b0, stall_v[3]}, 1);
    #2;
    reset = 1;
    #1;
    chk("arst_stall", {31'b0, stall_v[3]}, 0);
    chk("arst_mask", {24'b0, got_mask[3]}, 0);
    chk("arst_cnt", got_cnt[3], 0);
    model_clear();
    advance();
    reset = 0;

    // Saturation of the 4-bit counters.
    drive(0, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_cnt1", got_cnt[1], 15);
    chk("sat_cnt3", got_cnt[3], 15);
    chk("sat_cnt0", got_cnt[0], 20);

    // Random traffic over a small register set to provoke frequent hits.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
